// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response encodings, FSM state types and burst header check
// Contents: burst_t, RESP_OKAY/RESP_SLVERR, w_state_t, r_state_t, hdr_err()
package axi_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10, BURST_RSVD = 2'b11} burst_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  // A burst header is bad when the beat is wider than the bus, the burst type is reserved,
  // or a WRAP burst has a length that does not give a power-of-two window.
  function automatic logic hdr_err(input logic [2:0] size, input logic [7:0] len,
                                   input logic [1:0] burst, input logic [2:0] max_size);
    return size > max_size || burst == BURST_RSVD ||
           (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address for FIXED/INCR/WRAP bursts (reserved steps like INCR)
// Ports: addr/size/len/burst in (current beat), next_addr out
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] incr, mask;
  always_comb begin
    incr = addr + (ADDR_WIDTH'(1) << size);
    // WRAP window is (len+1)*(1<<size) bytes; legal lengths make it a power of two
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr = burst == BURST_FIXED ? addr :
                burst == BURST_WRAP  ? (addr & ~mask) | (incr & mask) : incr;
  end
endmodule

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 slave backed by a MEM_DEPTH-word array, independent write and read FSMs
// Ports: clk, rst (async active-high); AW/W/B write channels; AR/R read channels
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BYTES);
  localparam int MW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(OFF);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_next, w_idx;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err, w_fire, w_beat_err;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next, nx_addr, nx_idx;
  logic [7:0]            r_len, r_cnt, nx_len, nx_cnt;
  logic [2:0]            r_size, nx_size;
  logic [1:0]            r_burst, nx_burst, nx_resp;
  logic                  nx_oor, nx_last;
  logic [DATA_WIDTH-1:0] nx_data;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_gen (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_next)
  );
  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_gen (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_next)
  );

  assign w_fire = wvalid && wready;
  assign w_idx = w_addr >> OFF;
  assign w_beat_err = hdr_err(w_size, w_len, w_burst, MAX_SIZE) || w_idx >= DEPTH ||
                      (wlast != (w_cnt == w_len));

  // Memory is deliberately outside the reset domain so partial writes survive a reset.
  always_ff @(posedge clk)
    if (w_fire && !w_beat_err)
      for (int b = 0; b < BYTES; b++)
        if (wstrb[b]) mem[w_idx[MW-1:0]][8*b +: 8] <= wdata[8*b +: 8];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA:
          if (w_fire) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err | w_beat_err;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        W_RESP:
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase

  // Source of the next beat to present: the AR channel itself when idle, else the stepped address.
  always_comb begin
    nx_addr  = arready ? araddr : r_next;
    nx_len   = arready ? arlen : r_len;
    nx_size  = arready ? arsize : r_size;
    nx_burst = arready ? arburst : r_burst;
    nx_cnt   = arready ? 8'd0 : r_cnt + 8'd1;
    nx_idx   = nx_addr >> OFF;
    nx_oor   = nx_idx >= DEPTH;
    nx_data  = nx_oor ? '0 : mem[nx_idx[MW-1:0]];
    nx_resp  = (hdr_err(nx_size, nx_len, nx_burst, MAX_SIZE) || nx_oor) ? RESP_SLVERR : RESP_OKAY;
    nx_last  = nx_cnt == nx_len;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rdata   <= nx_data;
            rresp   <= nx_resp;
            rlast   <= nx_last;
            r_state <= R_DATA;
          end
        end
        R_DATA:
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_cnt  <= nx_cnt;
              rdata  <= nx_data;
              rresp  <= nx_resp;
              rlast  <= nx_last;
            end
          end
        default: r_state <= R_IDLE;
      endcase
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: scoreboard bench for axi_sram_responder with a byte-level memory model
module tb_axi_sram_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;

  always #5 clk = ~clk;

  axi_sram_responder dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

  int vectors = 0, miscompares = 0;
  logic [31:0] mdl [int];
  b_exp_t bq[$];
  r_exp_t rq[$];

  function automatic logic [31:0] mdl_next(input logic [31:0] a, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst);
    int unsigned step, win, lo;
    step = 1 << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      win = (int'(len) + 1) * step;
      lo = a - a % win;
      return lo + (a - lo + step) % win;
    end
    return a + step;
  endfunction

  function automatic bit mdl_hdr_bad(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    return size > 3'd2 || burst == 2'b11 ||
           (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
  endfunction

  function automatic bit mdl_oor(input logic [31:0] a);
    return (a >> 2) >= 32'd256;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (mdl_oor(a) || !mdl.exists(int'(a >> 2))) return 32'h0;
    return mdl[int'(a >> 2)];
  endfunction

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                          input logic [3:0] strb, input bit early_last);
    logic [31:0] a, dv, old;
    int nb, n;
    bit err, be, lst;
    b_exp_t e;
    err = 0;
    a = addr;
    nb = early_last ? int'(len) : int'(len) + 1;
    for (int i = 0; i < nb; i++) begin
      lst = (i == nb - 1);
      be = mdl_hdr_bad(size, len, burst) || mdl_oor(a) || (lst != (i == int'(len)));
      dv = d0 + 32'(i);
      if (!be) begin
        old = mdl_rd(a);
        for (int b = 0; b < 4; b++) if (strb[b]) old[8*b +: 8] = dv[8*b +: 8];
        mdl[int'(a >> 2)] = old;
      end
      err |= be;
      a = mdl_next(a, size, len, burst);
    end
    bq.push_back({id, err ? 2'b10 : 2'b00});
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL aw_timeout got awready=%b want 1", awready);
      awvalid = 1'b0; void'(bq.pop_back()); return;
    end
    @(negedge clk);
    awvalid = 1'b0;
    vectors++;
    if (wready !== 1'b1) begin miscompares++; $display("FAIL wready_latency got %b want 1", wready); end
    for (int i = 0; i < nb; i++) begin
      wdata = d0 + 32'(i); wstrb = strb; wlast = (i == nb - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    vectors++;
    if (bvalid !== 1'b1) begin miscompares++; $display("FAIL bvalid_latency got %b want 1", bvalid); end
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    e = bq.pop_front();
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL b_timeout got bvalid=%b want 1", bvalid); return;
    end
    vectors++;
    if (bid !== e.id || bresp !== e.resp) begin
      miscompares++;
      $display("FAIL b_resp got id=%h resp=%b want id=%h resp=%b", bid, bresp, e.id, e.resp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      miscompares++;
      $display("FAIL b_release got bvalid=%b awready=%b want 0 1", bvalid, awready);
    end
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_at);
    logic [31:0] a;
    int n;
    r_exp_t e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id; e.data = mdl_rd(a);
      e.resp = (mdl_hdr_bad(size, len, burst) || mdl_oor(a)) ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      rq.push_back(e);
      a = mdl_next(a, size, len, burst);
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL ar_timeout got arready=%b want 1", arready);
      arvalid = 1'b0; rq.delete(); return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1) begin miscompares++; $display("FAIL rvalid_latency got %b want 1", rvalid); end
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
        vectors++; miscompares++;
        $display("FAIL r_timeout beat %0d got rvalid=%b want 1", i, rvalid);
        rq.delete(); rready = 1'b0; return;
      end
      e = rq.pop_front();
      if (i == stall_at) begin
        rready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          vectors++;
          if (rvalid !== 1'b1 || rid !== e.id || rdata !== e.data || rlast !== e.last) begin
            miscompares++;
            $display("FAIL r_stall beat %0d got v=%b id=%h data=%h last=%b want 1 %h %h %b",
                     i, rvalid, rid, rdata, rlast, e.id, e.data, e.last);
          end
        end
        rready = 1'b1;
      end
      vectors++;
      if (rid !== e.id || rdata !== e.data || rresp !== e.resp || rlast !== e.last) begin
        miscompares++;
        $display("FAIL r_beat%0d got id=%h data=%h resp=%b last=%b want id=%h data=%h resp=%b last=%b",
                 i, rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
      end
      @(negedge clk);
    end
    rready = 1'b0;
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_done got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; awvalid = 1'b1; arvalid = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b rdata=%h want all 0",
               awready, wready, bvalid, arready, rvalid, rdata);
    end
    awvalid = 1'b0; arvalid = 1'b0; rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got awready=%b arready=%b want 1 1", awready, arready);
    end
  endtask

  task automatic test_incr();
    wr_burst(4'h1, 32'h10, 8'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 0);
    rd_burst(4'h2, 32'h10, 8'd3, 3'd2, 2'b01, -1);
  endtask

  task automatic test_wrap();
    rd_burst(4'h3, 32'h18, 8'd3, 3'd2, 2'b10, -1);
    wr_burst(4'h4, 32'h28, 8'd3, 3'd2, 2'b10, 32'hB0, 4'hF, 0);
    rd_burst(4'h5, 32'h20, 8'd3, 3'd2, 2'b01, -1);
  endtask

  task automatic test_out_of_range();
    wr_burst(4'h6, 32'h0, 8'd0, 3'd2, 2'b01, 32'h55AA55AA, 4'hF, 0);
    wr_burst(4'h7, 32'h400, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 0);
    rd_burst(4'h8, 32'h400, 8'd0, 3'd2, 2'b01, -1);
    rd_burst(4'h9, 32'h0, 8'd0, 3'd2, 2'b01, -1);
  endtask

  task automatic test_strobe();
    wr_burst(4'hA, 32'h40, 8'd0, 3'd2, 2'b01, 32'h11223344, 4'hF, 0);
    wr_burst(4'hB, 32'h40, 8'd0, 3'd2, 2'b01, 32'hDDCCBBAA, 4'b0101, 0);
    rd_burst(4'hC, 32'h40, 8'd0, 3'd2, 2'b01, -1);
  endtask

  task automatic test_errors();
    wr_burst(4'h0, 32'h50, 8'd1, 3'd2, 2'b01, 32'h0BADF000, 4'hF, 0);
    wr_burst(4'h1, 32'h50, 8'd0, 3'd3, 2'b01, 32'h11111111, 4'hF, 0);
    wr_burst(4'h2, 32'h50, 8'd2, 3'd2, 2'b10, 32'h22222222, 4'hF, 0);
    wr_burst(4'h3, 32'h50, 8'd1, 3'd2, 2'b01, 32'h33333333, 4'hF, 1);
    rd_burst(4'h4, 32'h10, 8'd1, 3'd2, 2'b11, -1);
    rd_burst(4'h5, 32'h10, 8'd0, 3'd3, 2'b01, -1);
    rd_burst(4'h6, 32'h50, 8'd1, 3'd2, 2'b01, -1);
  endtask

  task automatic test_fixed();
    wr_burst(4'h7, 32'h60, 8'd2, 3'd2, 2'b00, 32'hC0, 4'hF, 0);
    rd_burst(4'h8, 32'h60, 8'd2, 3'd2, 2'b00, -1);
  endtask

  task automatic test_concurrent();
    fork
      rd_burst(4'hD, 32'h10, 8'd3, 3'd2, 2'b01, 1);
      wr_burst(4'hE, 32'h80, 8'd7, 3'd2, 2'b01, 32'hE0, 4'hF, 0);
    join
    rd_burst(4'hF, 32'h80, 8'd7, 3'd2, 2'b01, -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [7:0] l;
    for (int k = 0; k < 4; k++) begin
      a = 32'h100 + 32'($urandom_range(0, 63)) * 4;
      l = 8'($urandom_range(0, 7));
      wr_burst(4'(k), a, l, 3'd2, 2'b01, $urandom, 4'hF, 0);
      rd_burst(4'(k + 8), a, l, 3'd2, 2'b01, -1);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    @(negedge clk);
    awid = 4'h9; awaddr = 32'hC0; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'hF0 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      mdl[int'((32'hC0 + 32'(4 * i)) >> 2)] = 32'hF0 + 32'(i);
      @(negedge clk);
    end
    wdata = 32'hF2;
    rst = 1'b1;
    #1;
    wvalid = 1'b0;
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got aw=%b w=%b b=%b ar=%b r=%b want all 0",
               awready, wready, bvalid, arready, rvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1) begin miscompares++; $display("FAIL midreset_awready got %b want 1", awready); end
    repeat (3) begin
      vectors++;
      if (bvalid !== 1'b0) begin miscompares++; $display("FAIL midreset_bvalid got %b want 0", bvalid); end
      @(negedge clk);
    end
    rd_burst(4'h3, 32'hC0, 8'd1, 3'd2, 2'b01, -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_out_of_range();
    test_strobe();
    test_errors();
    test_fixed();
    test_concurrent();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
